// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and defaults for the square-root control FSM.
package sqrt_ctrl_pkg;

    localparam int unsigned ITER_W_DEF   = 9;
    localparam int unsigned MAX_ITER_DEF = 256;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        TEST     = 3'd2,
        UPD_ROOT = 3'd3,
        UPD_SQ   = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_e;

    typedef struct packed {
        logic boot;
        logic wr_square;
        logic wr_root;
        logic muxes;
    } strobe_t;

    // Datapath control strobes asserted while the FSM sits in a given state.
    function automatic strobe_t strobes_for(input state_e s);
        strobe_t st;
        st = '0;
        case (s)
            INIT: begin
                st.boot      = 1'b1;
                st.wr_square = 1'b1;
                st.wr_root   = 1'b1;
            end
            UPD_ROOT: begin
                st.wr_root = 1'b1;
                st.muxes   = 1'b1;
            end
            UPD_SQ: begin
                st.wr_square = 1'b1;
                st.muxes     = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sqrt_ctrl_fsm.sv
// Control FSM for the iterative 16-bit square-root datapath.
// Optional watchdog abort enabled by defining SQRT_CTRL_WATCHDOG_EN.
module sqrt_ctrl_fsm
    import sqrt_ctrl_pkg::*;
#(
    parameter int unsigned ITER_W   = ITER_W_DEF,
    parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              N_i,
    output logic              boot_o,
    output logic              wr_square_o,
    output logic              wr_root_o,
    output logic              muxes_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              error_o
);

    if (MAX_ITER >= (1 << ITER_W)) begin : g_cfg_check
        $error("sqrt_ctrl_fsm: ITER_W too narrow for MAX_ITER");
    end

    state_e            state_q, state_d;
    strobe_t           strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ITER_W-1:0] iter_q, iter_d;

`ifdef SQRT_CTRL_WATCHDOG_EN
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    logic error_q, error_d;
`endif

    // Next state and iteration count; outputs are decoded from the next state
    // so the registered strobes line up with the registered state.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
`ifdef SQRT_CTRL_WATCHDOG_EN
        error_d = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = INIT;
                    iter_d  = '0;
`ifdef SQRT_CTRL_WATCHDOG_EN
                    error_d = 1'b0;
`endif
                end
            end
            INIT:     state_d = TEST;
            TEST:     state_d = N_i ? DONE : UPD_ROOT;
            UPD_ROOT: state_d = UPD_SQ;
            UPD_SQ: begin
                iter_d  = iter_q + ITER_W'(1);
                state_d = TEST;
`ifdef SQRT_CTRL_WATCHDOG_EN
                if (iter_q == ITER_LAST) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
`endif
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        strobe_d = strobes_for(state_d);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE) || (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            strobe_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            iter_q   <= '0;
`ifdef SQRT_CTRL_WATCHDOG_EN
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            iter_q   <= iter_d;
`ifdef SQRT_CTRL_WATCHDOG_EN
            error_q  <= error_d;
`endif
        end
    end

    assign boot_o      = strobe_q.boot;
    assign wr_square_o = strobe_q.wr_square;
    assign wr_root_o   = strobe_q.wr_root;
    assign muxes_o     = strobe_q.muxes;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign iter_o      = iter_q;

`ifdef SQRT_CTRL_WATCHDOG_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_ctrl_fsm.sv
// Self-checking bench for sqrt_ctrl_fsm; expectations follow SQRT_CTRL_WATCHDOG_EN.
module tb_sqrt_ctrl_fsm;

    localparam int unsigned ITER_W = 9;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic              N_i;
    logic              boot_o;
    logic              wr_square_o;
    logic              wr_root_o;
    logic              muxes_o;
    logic              busy_o;
    logic              done_o;
    logic [ITER_W-1:0] iter_o;
    logic              error_o;

    int n_checks;
    int n_fail;

    logic [15:0] v_r;
    int unsigned k_m;
    bit          force_n0;

    sqrt_ctrl_fsm #(.ITER_W(ITER_W), .MAX_ITER(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .N_i         (N_i),
        .boot_o      (boot_o),
        .wr_square_o (wr_square_o),
        .wr_root_o   (wr_root_o),
        .muxes_o     (muxes_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .iter_o      (iter_o),
        .error_o     (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: after k completed updates the square register holds (k+1)^2.
    always @(posedge clk) begin
        if (rst || boot_o)
            k_m <= 0;
        else if (wr_square_o && muxes_o)
            k_m <= k_m + 1;
    end
    assign N_i = force_n0 ? 1'b0 : (32'(v_r) < (k_m + 32'd1) * (k_m + 32'd1));

    function automatic int isqrt(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return int'(r);
    endfunction

    function automatic string exp_trace(input int r, input bit wd_abort);
        string s;
        s = "IT";
        for (int i = 0; i < r; i++) s = {s, "RST"};
        if (wd_abort) s = {s, "RSD"};
        else s = {s, "D"};
        return s;
    endfunction

    function automatic string letter();
        if (boot_o && wr_square_o && wr_root_o && !muxes_o) return "I";
        if (done_o) return "D";
        if (wr_root_o && muxes_o && !wr_square_o) return "R";
        if (wr_square_o && muxes_o && !wr_root_o) return "S";
        if (busy_o && !boot_o && !wr_root_o && !wr_square_o) return "T";
        return "?";
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_trace(input string name, input string act, input string exp);
        int first;
        n_checks++;
        if (act != exp) begin
            n_fail++;
            first = 0;
            while (first < act.len() && first < exp.len() && act[first] == exp[first]) first++;
            $display("FAIL %s: trace len %0d differs from expected len %0d at index %0d",
                     name, act.len(), exp.len(), first);
        end
    endtask

    task automatic chk_inv();
        logic any_strobe;
        any_strobe = boot_o | wr_square_o | wr_root_o | muxes_o;
        n_checks++;
        if (((!busy_o || done_o) && any_strobe) ||
            (wr_root_o && wr_square_o && !boot_o) ||
            (done_o && !busy_o)) begin
            n_fail++;
            $display("FAIL strobe_invariant: busy=%0b done=%0b boot=%0b wsq=%0b wrt=%0b mux=%0b",
                     busy_o, done_o, boot_o, wr_square_o, wr_root_o, muxes_o);
        end
    endtask

    // Start a computation and record one letter per cycle up to done_o or the budget.
    task automatic run_v(input logic [15:0] v, input int budget, input bit hold,
                         output string tr, output bit got_done);
        @(negedge clk);
        v_r     = v;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
        tr       = "";
        got_done = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            chk_inv();
            tr = {tr, letter()};
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [15:0] v;
        int          exp_cyc;
        int          exp_iter;
    } vec_t;

    vec_t  tbl[8];
    string tr;
    bit    got;
    int    r;
    int    cyc;
    int    done_cnt;
    logic [15:0] rv;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start_i  = 1'b0;
        v_r      = '0;
        force_n0 = 1'b0;

        tbl[0] = '{16'd0,     3,   0};
        tbl[1] = '{16'd1,     6,   1};
        tbl[2] = '{16'd3,     6,   1};
        tbl[3] = '{16'd4,     9,   2};
        tbl[4] = '{16'd15,    12,  3};
        tbl[5] = '{16'd16,    15,  4};
        tbl[6] = '{16'd255,   48,  15};
        tbl[7] = '{16'd65535, 768, 255};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({boot_o, wr_square_o, wr_root_o, muxes_o, busy_o, done_o, error_o}), 32'd0);
        chk("reset_iter", 32'(iter_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_v(tbl[i].v, 1000, 1'b0, tr, got);
            chk($sformatf("done_seen v=%0d", tbl[i].v), 32'(got), 32'd1);
            chk($sformatf("latency v=%0d", tbl[i].v), 32'(tr.len()), 32'(tbl[i].exp_cyc));
            chk($sformatf("iter v=%0d", tbl[i].v), 32'(iter_o), 32'(tbl[i].exp_iter));
            chk($sformatf("error v=%0d", tbl[i].v), 32'(error_o), 32'd0);
            chk_trace($sformatf("trace v=%0d", tbl[i].v), tr, exp_trace(tbl[i].exp_iter, 1'b0));
            @(posedge clk);
            #1;
            chk($sformatf("post_done v=%0d", tbl[i].v), 32'({busy_o, done_o}), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("iter_hold v=%0d", tbl[i].v), 32'(iter_o), 32'(tbl[i].exp_iter));
        end

        for (int i = 0; i < 6; i++) begin
            rv = 16'($urandom_range(0, 65535));
            r  = isqrt(32'(rv));
            run_v(rv, 1000, 1'b0, tr, got);
            chk($sformatf("rand_done v=%0d", rv), 32'(got), 32'd1);
            chk($sformatf("rand_latency v=%0d", rv), 32'(tr.len()), 32'(3 + 3 * r));
            chk($sformatf("rand_iter v=%0d", rv), 32'(iter_o), 32'(r));
            chk_trace($sformatf("rand_trace v=%0d", rv), tr, exp_trace(r, 1'b0));
            @(posedge clk);
        end

        // start_i held high: the next INIT appears only after DONE has returned to IDLE
        run_v(16'd4, 100, 1'b1, tr, got);
        chk("hold_latency", 32'(tr.len()), 32'd9);
        @(posedge clk);
        #1;
        chk("hold_idle_after_done", 32'({busy_o, boot_o}), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_restart_init", 32'({busy_o, boot_o}), 32'b11);
        start_i = 1'b0;
        cyc = 1;
        while (!done_o && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("hold_second_latency", 32'(cyc), 32'd9);
        @(posedge clk);

        // start_i toggled while busy and during DONE is dropped
        @(negedge clk);
        v_r     = 16'd16;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        while (!done_o && cyc < 100) begin
            start_i = (cyc % 2 == 1);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("pulse_latency", 32'(cyc), 32'd15);
        chk("pulse_iter", 32'(iter_o), 32'd4);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy_o) done_cnt++;
            @(posedge clk);
            #1;
        end
        chk("pulse_dropped", 32'(done_cnt), 32'd0);

        // synchronous reset while in UPD_ROOT aborts without done_o
        @(negedge clk);
        v_r     = 16'd16;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cyc = 0;
        while (!(wr_root_o && muxes_o) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_upd_root", 32'(wr_root_o && muxes_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_reset_outputs", 32'({boot_o, wr_square_o, wr_root_o, muxes_o, busy_o, done_o, error_o}), 32'd0);
        chk("midrun_reset_iter", 32'(iter_o), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) done_cnt++;
        end
        chk("midrun_no_done", 32'(done_cnt), 32'd0);

        force_n0 = 1'b1;
`ifdef SQRT_CTRL_WATCHDOG_EN
        run_v(16'd0, 1000, 1'b0, tr, got);
        chk("wd_done", 32'(got), 32'd1);
        chk("wd_latency", 32'(tr.len()), 32'd770);
        chk("wd_error", 32'(error_o), 32'd1);
        chk("wd_iter", 32'(iter_o), 32'd256);
        chk_trace("wd_trace", tr, exp_trace(255, 1'b1));
        @(posedge clk);
        #1;
        chk("wd_error_sticky", 32'({error_o, busy_o, done_o}), 32'b100);
        force_n0 = 1'b0;
        run_v(16'd9, 100, 1'b0, tr, got);
        chk("wd_error_cleared", 32'(error_o), 32'd0);
        chk("wd_after_iter", 32'(iter_o), 32'd3);
`else
        run_v(16'd0, 2000, 1'b0, tr, got);
        chk("no_wd_no_done", 32'(got), 32'd0);
        chk("no_wd_error", 32'(error_o), 32'd0);
        chk("no_wd_busy", 32'(busy_o), 32'd1);
        force_n0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("no_wd_reset", 32'({busy_o, done_o, iter_o}), 32'd0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
